dual_slope_ctrl: RTL and testbench

Phase sequencer for the voltmeter's dual-slope conversion. It drives the analog switch network (autozero, input, reference) and programs the down-stream timing counter through its en/limit/busy/done/count interface. It captures the de-integration count at the comparator zero-crossing and reports a signed result with a one-cycle valid pulse. It sits between the host command logic (start) and the timing counter.

---
 rtl/dsc_pkg.sv | 34 +++
 rtl/dual_slope_ctrl_if.sv | 13 +
 rtl/dual_slope_ctrl_cmp_sync.sv | 29 ++
 rtl/dual_slope_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsc_pkg.sv
// Shared definitions for the dual-slope conversion sequencer: state encoding,
// default phase limits, result width and the phase-to-limit helper.
package dsc_pkg;

  localparam int RES_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AZ     = 3'd1;
  localparam logic [2:0] ST_INT    = 3'd2;
  localparam logic [2:0] ST_DEINT  = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  localparam logic [RES_W-1:0] AZ_CYCLES_DEF  = 16'd1000;
  localparam logic [RES_W-1:0] INT_CYCLES_DEF = 16'd1000;
  localparam logic [RES_W-1:0] DEINT_MAX_DEF  = 16'd2047;

  // Counter limit to present while the sequencer sits in a given state.
  function automatic logic [RES_W-1:0] phase_limit(
    input logic [2:0]       st,
    input logic [RES_W-1:0] az_lim,
    input logic [RES_W-1:0] int_lim,
    input logic [RES_W-1:0] deint_lim
  );
    logic [RES_W-1:0] lim;
    case (st)
      ST_AZ:    lim = az_lim;
      ST_INT:   lim = int_lim;
      ST_DEINT: lim = deint_lim;
      default:  lim = 16'd0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/dual_slope_ctrl_if.sv
// Handshake between the conversion sequencer (master) and the timing counter (slave).
interface dual_slope_ctrl_if;
  import dsc_pkg::*;

  logic             en;
  logic [RES_W-1:0] limit;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] count;

  modport master (output en, limit, input busy, done, count);
  modport slave  (input en, limit, output busy, done, count);
endinterface

// File: rtl/dual_slope_ctrl_cmp_sync.sv
// Two-flop synchronizer for the asynchronous integrator comparator.
module cmp_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope conversion phase sequencer. Define DSC_AUTOZERO_EN to run an
// autozero phase before each integrate phase; otherwise IDLE goes straight to INT.
module dual_slope_ctrl
  import dsc_pkg::*;
#(
  parameter logic [RES_W-1:0] AZ_CYCLES  = AZ_CYCLES_DEF,
  parameter logic [RES_W-1:0] INT_CYCLES = INT_CYCLES_DEF,
  parameter logic [RES_W-1:0] DEINT_MAX  = DEINT_MAX_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                cmp_i,
  dual_slope_ctrl_if.master   cnt,
  output logic                sw_az_o,
  output logic                sw_vin_o,
  output logic                sw_ref_o,
  output logic                ref_neg_o,
  output logic                busy_o,
  output logic                valid_o,
  output logic [RES_W-1:0]    result_o,
  output logic                sign_o,
  output logic                overrange_o
);

`ifdef DSC_AUTOZERO_EN
  localparam logic [2:0] FIRST_PHASE = ST_AZ;
`else
  localparam logic [2:0] FIRST_PHASE = ST_INT;
`endif

  logic cmp_s;
  logic trip_s;

  logic [2:0]       state_d, state_q;
  logic             tripped_d, tripped_q;
  logic [RES_W-1:0] cap_d, cap_q;
  logic             sign_d, sign_q;
  logic             ref_neg_d, ref_neg_q;
  logic [RES_W-1:0] result_d, result_q;
  logic             sign_out_d, sign_out_q;
  logic             ovr_d, ovr_q;
  logic             cnt_en_d, cnt_en_q;
  logic [RES_W-1:0] cnt_limit_d, cnt_limit_q;
  logic             sw_az_d, sw_az_q;
  logic             sw_vin_d, sw_vin_q;
  logic             sw_ref_d, sw_ref_q;
  logic             busy_d, busy_q;
  logic             valid_d, valid_q;

  cmp_sync u_cmp_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cmp_i),
    .q_o   (cmp_s)
  );

  // Zero-crossing: integrator has returned to the polarity opposite its charge.
  assign trip_s = (state_q == ST_DEINT) && !tripped_q && (cmp_s == sign_q);

  always_comb begin
    state_d    = state_q;
    tripped_d  = tripped_q;
    cap_d      = cap_q;
    sign_d     = sign_q;
    ref_neg_d  = ref_neg_q;
    result_d   = result_q;
    sign_out_d = sign_out_q;
    ovr_d      = ovr_q;

    case (state_q)
      ST_IDLE: begin
        tripped_d = 1'b0;
        if (start_i && !cnt.busy) begin
          state_d = FIRST_PHASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AZ: begin
        if (cnt.done) begin
          state_d = ST_INT;
        end else begin
          state_d = ST_AZ;
        end
      end
      ST_INT: begin
        if (cnt.done) begin
          sign_d    = ~cmp_s;
          ref_neg_d = cmp_s;
          state_d   = ST_DEINT;
        end else begin
          state_d   = ST_INT;
        end
      end
      ST_DEINT: begin
        if (trip_s) begin
          tripped_d = 1'b1;
          cap_d     = cnt.count;
        end else begin
          tripped_d = tripped_q;
        end
        // A crossing in the done cycle itself still counts as in range.
        if (cnt.done) begin
          state_d    = ST_REPORT;
          sign_out_d = sign_q;
          ovr_d      = ~(tripped_q | trip_s);
          if (tripped_q) begin
            result_d = cap_q;
          end else if (trip_s) begin
            result_d = cnt.count;
          end else begin
            result_d = DEINT_MAX;
          end
        end else begin
          state_d = ST_DEINT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Registered outputs follow the next state so they change on the transition edge.
    cnt_en_d    = (state_d == ST_AZ) || (state_d == ST_INT) || (state_d == ST_DEINT);
    cnt_limit_d = phase_limit(state_d, AZ_CYCLES, INT_CYCLES, DEINT_MAX);
`ifdef DSC_AUTOZERO_EN
    sw_az_d     = (state_d == ST_AZ);
`else
    sw_az_d     = 1'b0;
`endif
    sw_vin_d    = (state_d == ST_INT);
    sw_ref_d    = (state_d == ST_DEINT);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tripped_q   <= 1'b0;
      cap_q       <= 16'd0;
      sign_q      <= 1'b0;
      ref_neg_q   <= 1'b0;
      result_q    <= 16'd0;
      sign_out_q  <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_limit_q <= 16'd0;
      sw_az_q     <= 1'b0;
      sw_vin_q    <= 1'b0;
      sw_ref_q    <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tripped_q   <= tripped_d;
      cap_q       <= cap_d;
      sign_q      <= sign_d;
      ref_neg_q   <= ref_neg_d;
      result_q    <= result_d;
      sign_out_q  <= sign_out_d;
      ovr_q       <= ovr_d;
      cnt_en_q    <= cnt_en_d;
      cnt_limit_q <= cnt_limit_d;
      sw_az_q     <= sw_az_d;
      sw_vin_q    <= sw_vin_d;
      sw_ref_q    <= sw_ref_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  assign cnt.en      = cnt_en_q;
  assign cnt.limit   = cnt_limit_q;
  assign sw_az_o     = sw_az_q;
  assign sw_vin_o    = sw_vin_q;
  assign sw_ref_o    = sw_ref_q;
  assign ref_neg_o   = ref_neg_q;
  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign sign_o      = sign_out_q;
  assign overrange_o = ovr_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with a behavioural timing counter
// (AZ=4, INT=8, DEINT_MAX=40); follows DSC_AUTOZERO_EN like the design.
module tb_dual_slope_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        cmp_i;
  logic        sw_az_o, sw_vin_o, sw_ref_o, ref_neg_o;
  logic        busy_o, valid_o, sign_o, overrange_o;
  logic [15:0] result_o;
  logic [15:0] cnt_q;
  logic        busy_force;

  int nchecks = 0;
  int nerrors = 0;
  int multi_sw = 0;
  int az_seen = 0;

  dual_slope_ctrl_if cnt_if ();

  dual_slope_ctrl #(
    .AZ_CYCLES  (16'd4),
    .INT_CYCLES (16'd8),
    .DEINT_MAX  (16'd40)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_i),
    .cmp_i       (cmp_i),
    .cnt         (cnt_if),
    .sw_az_o     (sw_az_o),
    .sw_vin_o    (sw_vin_o),
    .sw_ref_o    (sw_ref_o),
    .ref_neg_o   (ref_neg_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .sign_o      (sign_o),
    .overrange_o (overrange_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: counts 0..limit while enabled, done at limit, then restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else if (!cnt_if.en) cnt_q <= 16'd0;
    else if (cnt_q == cnt_if.limit) cnt_q <= 16'd0;
    else cnt_q <= cnt_q + 16'd1;
  end
  assign cnt_if.count = cnt_q;
  assign cnt_if.done  = cnt_if.en && (cnt_q == cnt_if.limit);
  assign cnt_if.busy  = cnt_if.en || busy_force;

  always @(negedge clk) begin
    if ((32'(sw_az_o) + 32'(sw_vin_o) + 32'(sw_ref_o)) > 1) multi_sw++;
    if (sw_az_o) az_seen++;
  end

  task automatic run_conv(input logic cmp_int, input int trip_at, input int glitch_at,
                          input int recross_at, input bit pulse_start,
                          output int n_valid, output logic [15:0] res, output logic sgn,
                          output logic ovr, output logic rneg, output int lat, output bit tmo);
    int  done_c;
    bit  seen;
    done_c = -100; seen = 1'b0; n_valid = 0; lat = -1; tmo = 1'b1;
    res = 16'hxxxx; sgn = 1'bx; ovr = 1'bx; rneg = 1'bx;
    @(negedge clk);
    cmp_i = cmp_int;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (sw_ref_o) begin
        rneg = ref_neg_o;
        if (cnt_q == trip_at)    cmp_i = ~cmp_int;
        if (cnt_q == glitch_at)  cmp_i = cmp_int;
        if (cnt_q == recross_at) cmp_i = ~cmp_int;
        if (cnt_if.done) done_c = c;
      end
      start_i = pulse_start && sw_vin_o && (cnt_q == 16'd3);
      if (valid_o) begin
        n_valid++;
        res = result_o; sgn = sign_o; ovr = overrange_o;
        lat = c - done_c;
        seen = 1'b1;
      end
      if (seen && !busy_o) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; cmp_i = 1'b0; busy_force = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchecks++;
    if ({cnt_if.en, cnt_if.limit, sw_az_o, sw_vin_o, sw_ref_o, ref_neg_o, busy_o, valid_o,
         result_o, sign_o, overrange_o} !== 41'd0) begin
      nerrors++;
      $display("FAIL reset_outputs: en=%b lim=%0d sw=%b%b%b rn=%b busy=%b valid=%b res=%0d sg=%b ovr=%b, required all 0",
               cnt_if.en, cnt_if.limit, sw_az_o, sw_vin_o, sw_ref_o, ref_neg_o, busy_o, valid_o,
               result_o, sign_o, overrange_o);
    end
  endtask

  task automatic test_first_phase;
    int n; logic [15:0] r; logic s, o, rn; int lat; bit tmo;
    @(negedge clk);
    cmp_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    nchecks++;
`ifdef DSC_AUTOZERO_EN
    if ({sw_az_o, sw_vin_o, cnt_if.limit, cnt_if.en, busy_o} !== {1'b1, 1'b0, 16'd4, 1'b1, 1'b1}) begin
      nerrors++;
      $display("FAIL first_phase: az=%b vin=%b lim=%0d en=%b busy=%b, required az=1 lim=4 en=1 busy=1",
               sw_az_o, sw_vin_o, cnt_if.limit, cnt_if.en, busy_o);
    end
`else
    if ({sw_az_o, sw_vin_o, cnt_if.limit, cnt_if.en, busy_o} !== {1'b0, 1'b1, 16'd8, 1'b1, 1'b1}) begin
      nerrors++;
      $display("FAIL first_phase: az=%b vin=%b lim=%0d en=%b busy=%b, required vin=1 lim=8 en=1 busy=1",
               sw_az_o, sw_vin_o, cnt_if.limit, cnt_if.en, busy_o);
    end
`endif
    for (int c = 0; c < 200 && busy_o; c++) @(negedge clk);
    nchecks++;
    if (busy_o !== 1'b0) begin
      nerrors++;
      $display("FAIL first_phase_end: busy=%b after 200 cycles, required 0", busy_o);
    end
    run_conv(1'b1, 17, -1, -1, 1'b0, n, r, s, o, rn, lat, tmo);
  endtask

  task automatic test_positive;
    int n; logic [15:0] r; logic s, o, rn; int lat; bit tmo;
    run_conv(1'b1, 17, -1, -1, 1'b0, n, r, s, o, rn, lat, tmo);
    nchecks++;
    if ({tmo, n, r, s, o, rn, lat} !== {1'b0, 32'd1, 16'd19, 1'b0, 1'b0, 1'b1, 32'd1}) begin
      nerrors++;
      $display("FAIL positive: tmo=%b nvalid=%0d res=%0d sign=%b ovr=%b refneg=%b lat=%0d, required 0 1 19 0 0 1 1",
               tmo, n, r, s, o, rn, lat);
    end
    repeat (5) @(negedge clk);
    nchecks++;
    if ({result_o, sign_o, overrange_o, valid_o} !== {16'd19, 1'b0, 1'b0, 1'b0}) begin
      nerrors++;
      $display("FAIL positive_hold: res=%0d sign=%b ovr=%b valid=%b, required 19 0 0 0",
               result_o, sign_o, overrange_o, valid_o);
    end
  endtask

  task automatic test_negative;
    int n; logic [15:0] r; logic s, o, rn; int lat; bit tmo;
    run_conv(1'b0, 5, -1, -1, 1'b0, n, r, s, o, rn, lat, tmo);
    nchecks++;
    if ({tmo, n, r, s, o, rn} !== {1'b0, 32'd1, 16'd7, 1'b1, 1'b0, 1'b0}) begin
      nerrors++;
      $display("FAIL negative: tmo=%b nvalid=%0d res=%0d sign=%b ovr=%b refneg=%b, required 0 1 7 1 0 0",
               tmo, n, r, s, o, rn);
    end
  endtask

  task automatic test_overrange;
    int n; logic [15:0] r; logic s, o, rn; int lat; bit tmo;
    run_conv(1'b1, -1, -1, -1, 1'b0, n, r, s, o, rn, lat, tmo);
    nchecks++;
    if ({tmo, n, r, s, o, lat} !== {1'b0, 32'd1, 16'd40, 1'b0, 1'b1, 32'd1}) begin
      nerrors++;
      $display("FAIL overrange: tmo=%b nvalid=%0d res=%0d sign=%b ovr=%b lat=%0d, required 0 1 40 0 1 1",
               tmo, n, r, s, o, lat);
    end
    run_conv(1'b0, -1, -1, -1, 1'b0, n, r, s, o, rn, lat, tmo);
    nchecks++;
    if ({tmo, n, r, s, o} !== {1'b0, 32'd1, 16'd40, 1'b1, 1'b1}) begin
      nerrors++;
      $display("FAIL overrange_neg: tmo=%b nvalid=%0d res=%0d sign=%b ovr=%b, required 0 1 40 1 1",
               tmo, n, r, s, o);
    end
  endtask

  task automatic test_glitch_and_start;
    int n; logic [15:0] r; logic s, o, rn; int lat; bit tmo; int busy_seen;
    run_conv(1'b1, 10, 14, 20, 1'b1, n, r, s, o, rn, lat, tmo);
    nchecks++;
    if ({tmo, n, r, s, o} !== {1'b0, 32'd1, 16'd12, 1'b0, 1'b0}) begin
      nerrors++;
      $display("FAIL glitch: tmo=%b nvalid=%0d res=%0d sign=%b ovr=%b, required 0 1 12 0 0",
               tmo, n, r, s, o);
    end
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_o || valid_o) busy_seen++;
    end
    nchecks++;
    if (busy_seen !== 0) begin
      nerrors++;
      $display("FAIL start_during_int: busy/valid cycles=%0d after conversion, required 0", busy_seen);
    end
  endtask

  task automatic test_busy_block;
    busy_force = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    nchecks++;
    if ({busy_o, cnt_if.en} !== 2'b00) begin
      nerrors++;
      $display("FAIL start_while_cnt_busy: busy=%b en=%b, required 0 0", busy_o, cnt_if.en);
    end
    busy_force = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++;
    if (busy_o !== 1'b0) begin
      nerrors++;
      $display("FAIL request_not_latched: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid;
    int n; logic [15:0] r; logic s, o, rn; int lat; bit tmo; bit hit;
    hit = 1'b0;
    @(negedge clk);
    cmp_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sw_ref_o && cnt_q == 16'd10) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    nchecks++;
    if (hit !== 1'b1) begin
      nerrors++;
      $display("FAIL reach_deint: reached=%b, required 1", hit);
    end
    #2 rst = 1'b1;
    #1;
    nchecks++;
    if ({cnt_if.en, cnt_if.limit, sw_az_o, sw_vin_o, sw_ref_o, ref_neg_o, busy_o, valid_o,
         result_o, sign_o, overrange_o} !== 41'd0) begin
      nerrors++;
      $display("FAIL reset_mid_deint: en=%b lim=%0d sw=%b%b%b rn=%b busy=%b valid=%b res=%0d sg=%b ovr=%b, required all 0",
               cnt_if.en, cnt_if.limit, sw_az_o, sw_vin_o, sw_ref_o, ref_neg_o, busy_o, valid_o,
               result_o, sign_o, overrange_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_conv(1'b1, 17, -1, -1, 1'b0, n, r, s, o, rn, lat, tmo);
    nchecks++;
    if ({tmo, n, r, s, o} !== {1'b0, 32'd1, 16'd19, 1'b0, 1'b0}) begin
      nerrors++;
      $display("FAIL after_reset_conv: tmo=%b nvalid=%0d res=%0d sign=%b ovr=%b, required 0 1 19 0 0",
               tmo, n, r, s, o);
    end
  endtask

  task automatic test_switches;
    nchecks++;
    if (multi_sw !== 0) begin
      nerrors++;
      $display("FAIL switch_exclusive: cycles with >1 switch=%0d, required 0", multi_sw);
    end
`ifndef DSC_AUTOZERO_EN
    nchecks++;
    if (az_seen !== 0) begin
      nerrors++;
      $display("FAIL az_disabled: sw_az_o high cycles=%0d, required 0", az_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_phase();
    test_positive();
    test_negative();
    test_overrange();
    test_glitch_and_start();
    test_busy_block();
    test_reset_mid();
    test_switches();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
